// File: rtl/data_memory_port_if.sv
// Load/store handshake between the Memory stage (master) and the data memory port (slave).
interface data_memory_port_if;
  logic        loadRequest;
  logic [31:0] addressRegister;
  logic        storeValid;
  logic [31:0] storeData;
  logic [3:0]  realStoreByteEnable;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        busy;

  modport master (
    output loadRequest, addressRegister, storeValid, storeData, realStoreByteEnable,
    input  loadData, loadDataValid, storeComplete, busy
  );

  modport slave (
    input  loadRequest, addressRegister, storeValid, storeData, realStoreByteEnable,
    output loadData, loadDataValid, storeComplete, busy
  );
endinterface

// File: rtl/data_memory_port.sv
// Word-organised data SRAM with a one-request-at-a-time load/store sequencer and fixed latencies.
// Optional DMEM_PERF_COUNTERS_EN adds loadCount/storeCount/waitCycles outputs.
module data_memory_port #(
  parameter int MEM_BYTES     = 65536,
  parameter int LOAD_LATENCY  = 2,
  parameter int STORE_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  data_memory_port_if.slave bus
`ifdef DMEM_PERF_COUNTERS_EN
  ,
  output logic [31:0] loadCount,
  output logic [31:0] storeCount,
  output logic [31:0] waitCycles
`endif
);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int IW    = (AW > 2) ? AW - 2 : 1;
  localparam int MAXL  = (LOAD_LATENCY > STORE_LATENCY) ? LOAD_LATENCY : STORE_LATENCY;
  localparam int CNT_W = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT, RESPOND} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IW-1:0]     r_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_mem [WORDS];
  logic [31:0]       r_load_data;
  logic              r_load_vld;
  logic              r_store_cmp;

  logic [IW-1:0]     w_in_idx;
  logic [IW-1:0]     w_acc_idx;
  logic [31:0]       w_acc_wdata;
  logic [3:0]        w_acc_be;
  logic              w_go_load;
  logic              w_go_store;
  logic              w_unused_addr;

  generate
    if (AW > 2) begin : g_idx
      assign w_in_idx = bus.addressRegister[AW-1:2];
    end else begin : g_idx_single
      assign w_in_idx = '0;
    end
  endgenerate

  assign w_unused_addr = ^{bus.addressRegister[31:AW], bus.addressRegister[1:0]};

  // The counter holds cycles left before the response; a latency of 1 responds straight from IDLE.
  always_comb begin
    w_go_load   = 1'b0;
    w_go_store  = 1'b0;
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    w_acc_be    = r_be;
    case (r_state)
      IDLE: begin
        w_acc_idx   = w_in_idx;
        w_acc_wdata = bus.storeData;
        w_acc_be    = bus.realStoreByteEnable;
        if (bus.storeValid)       w_go_store = (STORE_LATENCY == 1);
        else if (bus.loadRequest) w_go_load  = (LOAD_LATENCY == 1);
      end
      LOAD_WAIT:  w_go_load  = bus.loadRequest && (r_cnt == CNT_W'(1));
      STORE_WAIT: w_go_store = (r_cnt == CNT_W'(1));
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_load_vld  <= 1'b0;
      r_store_cmp <= 1'b0;
      r_load_data <= '0;
    end else begin
      r_load_vld  <= w_go_load;
      r_store_cmp <= w_go_store;
      if (w_go_load) r_load_data <= r_mem[w_acc_idx];
      case (r_state)
        IDLE: begin
          if (bus.storeValid) begin
            r_state <= w_go_store ? RESPOND : STORE_WAIT;
            r_cnt   <= CNT_W'(STORE_LATENCY - 1);
          end else if (bus.loadRequest) begin
            r_state <= w_go_load ? RESPOND : LOAD_WAIT;
            r_cnt   <= CNT_W'(LOAD_LATENCY - 1);
          end
        end
        LOAD_WAIT: begin
          if (!bus.loadRequest) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_go_load) r_state <= RESPOND;
          end
        end
        STORE_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_go_store) r_state <= RESPOND;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request capture and array write; a reset on the write edge drops the store.
  always_ff @(posedge clock) begin
    if (r_state == IDLE) begin
      r_idx   <= w_in_idx;
      r_wdata <= bus.storeData;
      r_be    <= bus.realStoreByteEnable;
    end
    if (!reset && w_go_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_be[b]) r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
      end
    end
  end

  assign bus.loadData      = r_load_data;
  assign bus.loadDataValid = r_load_vld;
  assign bus.storeComplete = r_store_cmp;
  assign bus.busy          = (r_state != IDLE);

`ifdef DMEM_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      loadCount  <= '0;
      storeCount <= '0;
      waitCycles <= '0;
    end else begin
      if (r_load_vld)  loadCount  <= loadCount + 32'd1;
      if (r_store_cmp) storeCount <= storeCount + 32'd1;
      if (r_state == LOAD_WAIT || r_state == STORE_WAIT) waitCycles <= waitCycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_memory_port.sv
// Directed bench for data_memory_port: vector table of loads/stores plus hand-written corner sequences.
module tb_data_memory_port;
  localparam int LL  = 2;
  localparam int SL0 = 1;
  localparam int SL1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, sel;
  logic        req_ld, req_st;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_be;
  int          total = 0;
  int          bad   = 0;
  int          n_ld  = 0;
  int          n_st  = 0;
  int          n_wt  = 0;

  data_memory_port_if bus0();
  data_memory_port_if bus1();

  assign bus0.loadRequest         = req_ld & ~sel;
  assign bus0.storeValid          = req_st & ~sel;
  assign bus0.addressRegister     = req_addr;
  assign bus0.storeData           = req_data;
  assign bus0.realStoreByteEnable = req_be;
  assign bus1.loadRequest         = req_ld & sel;
  assign bus1.storeValid          = req_st & sel;
  assign bus1.addressRegister     = req_addr;
  assign bus1.storeData           = req_data;
  assign bus1.realStoreByteEnable = req_be;

  wire        m_vld  = sel ? bus1.loadDataValid : bus0.loadDataValid;
  wire        m_cmp  = sel ? bus1.storeComplete : bus0.storeComplete;
  wire        m_busy = sel ? bus1.busy          : bus0.busy;
  wire [31:0] m_data = sel ? bus1.loadData      : bus0.loadData;

`ifdef DMEM_PERF_COUNTERS_EN
  logic [31:0] lc0, sc0, wc0, lc1, sc1, wc1;
`endif

  data_memory_port #(.MEM_BYTES(65536), .LOAD_LATENCY(LL), .STORE_LATENCY(SL0)) u_dut0 (
    .clock(clk), .reset(rst0), .bus(bus0)
`ifdef DMEM_PERF_COUNTERS_EN
    , .loadCount(lc0), .storeCount(sc0), .waitCycles(wc0)
`endif
  );

  data_memory_port #(.MEM_BYTES(1024), .LOAD_LATENCY(LL), .STORE_LATENCY(SL1)) u_dut1 (
    .clock(clk), .reset(rst1), .bus(bus1)
`ifdef DMEM_PERF_COUNTERS_EN
    , .loadCount(lc1), .storeCount(sc1), .waitCycles(wc1)
`endif
  );

  typedef struct {
    bit          is_store;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_store(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int lat);
    int k;
    @(negedge clk);
    req_st = 1'b1; req_addr = a; req_data = d; req_be = be;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        req_addr = a ^ 32'h0000_0FF0; req_data = ~d; req_be = ~be;
      end
    end while (!m_cmp && k < 12);
    chk({nm, " latency"}, 32'(k), 32'(lat));
    req_st = 1'b0;
    @(negedge clk);
    chk({nm, " after"}, {30'b0, m_cmp, m_busy}, 32'h0);
  endtask

  task automatic do_load(input string nm, input logic [31:0] a, input logic [31:0] exp,
                         input int lat);
    int k;
    @(negedge clk);
    req_ld = 1'b1; req_addr = a;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) req_addr = a ^ 32'h0000_0FF0;
    end while (!m_vld && k < 12);
    chk({nm, " latency"}, 32'(k), 32'(lat));
    chk({nm, " data"}, m_data, exp);
    req_ld = 1'b0;
    @(negedge clk);
    chk({nm, " after"}, {30'b0, m_vld, m_busy}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h0000_0200, 32'h1122_3344, 4'b1111, 32'h0};
    tbl[3] = '{1'b1, 32'h0000_0201, 32'h0000_AA00, 4'b0010, 32'h0};
    tbl[4] = '{1'b0, 32'h0000_0200, 32'h0,         4'b0000, 32'h1122_AA44};
    tbl[5] = '{1'b0, 32'h0000_0203, 32'h0,         4'b0000, 32'h1122_AA44};
    tbl[6] = '{1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 32'h0};
    tbl[7] = '{1'b1, 32'h0000_0300, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    tbl[8] = '{1'b0, 32'h0000_0300, 32'h0,         4'b0000, 32'hCAFE_F00D};
    tbl[9] = '{1'b0, 32'h0001_0300, 32'h0,         4'b0000, 32'hCAFE_F00D};

    sel = 1'b0; req_ld = 1'b0; req_st = 1'b0;
    req_addr = '0; req_data = '0; req_be = '0;
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset loadData", bus0.loadData, 32'h0);
    chk("reset flags", {29'b0, bus0.loadDataValid, bus0.storeComplete, bus0.busy}, 32'h0);
    rst0 = 1'b0; rst1 = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_store) begin
        do_store($sformatf("vec%0d store", i), tbl[i].addr, tbl[i].data, tbl[i].be, SL0);
        n_st++; n_wt += SL0 - 1;
      end else begin
        do_load($sformatf("vec%0d load", i), tbl[i].addr, tbl[i].exp, LL);
        n_ld++; n_wt += LL - 1;
      end
    end

    // Load abort: request withdrawn during the wait cycle.
    @(negedge clk);
    req_ld = 1'b1; req_addr = 32'h0000_0100;
    @(negedge clk);
    chk("abort wait", {30'b0, m_busy, m_vld}, 32'h2);
    req_ld = 1'b0;
    @(negedge clk);
    chk("abort idle", {30'b0, m_busy, m_vld}, 32'h0);
    @(negedge clk);
    chk("abort no pulse", {31'b0, m_vld}, 32'h0);
    n_wt += 1;
    do_load("post-abort load", 32'h0000_0100, 32'hDEAD_BEEF, LL);
    n_ld++; n_wt += LL - 1;

    // Store and load together: store first, one IDLE cycle, then the load.
    @(negedge clk);
    req_st = 1'b1; req_ld = 1'b1;
    req_addr = 32'h0000_0400; req_data = 32'h5A5A_1234; req_be = 4'b1111;
    @(negedge clk);
    chk("both store first", {30'b0, m_cmp, m_vld}, 32'h2);
    req_st = 1'b0;
    @(negedge clk);
    chk("both idle gap", {30'b0, m_busy, m_cmp}, 32'h0);
    @(negedge clk);
    chk("both load wait", {30'b0, m_busy, m_vld}, 32'h2);
    @(negedge clk);
    chk("both load valid", {31'b0, m_vld}, 32'h1);
    chk("both load data", m_data, 32'h5A5A_1234);
    req_ld = 1'b0;
    @(negedge clk);
    chk("both quiet", {30'b0, m_vld, m_busy}, 32'h0);
    n_st++; n_ld++; n_wt += LL - 1;

    // Reset in the middle of a three-cycle store on the second instance.
    sel = 1'b1;
    do_store("r3 store", 32'h0000_0040, 32'h0BAD_F00D, 4'b1111, SL1);
    do_load("r3 load", 32'h0000_0040, 32'h0BAD_F00D, LL);
    @(negedge clk);
    req_st = 1'b1; req_addr = 32'h0000_0040; req_data = 32'hFFFF_FFFF; req_be = 4'b1111;
    @(negedge clk);
    chk("r3 wait1", {30'b0, m_busy, m_cmp}, 32'h2);
    @(negedge clk);
    chk("r3 wait2", {30'b0, m_busy, m_cmp}, 32'h2);
    rst1 = 1'b1;
    @(negedge clk);
    chk("r3 reset loadData", m_data, 32'h0);
    chk("r3 reset flags", {29'b0, m_vld, m_cmp, m_busy}, 32'h0);
    rst1 = 1'b0; req_st = 1'b0;
    @(negedge clk);
    do_load("r3 unchanged", 32'h0000_0040, 32'h0BAD_F00D, LL);
    sel = 1'b0;

`ifdef DMEM_PERF_COUNTERS_EN
    chk("perf loadCount", lc0, 32'(n_ld));
    chk("perf storeCount", sc0, 32'(n_st));
    chk("perf waitCycles", wc0, 32'(n_wt));
`endif
    $display("tally: loads=%0d stores=%0d wait=%0d", n_ld, n_st, n_wt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
